// File: rtl/mem_responder.sv
// Unified instruction/data memory responder: request/ready handshake, programmable
// wait states, byte-masked writes, and error flagging of misaligned/out-of-range accesses.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wmask_q, wmask_d;
  logic               bad_q, bad_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [31:0]        mem_q [DEPTH_WORDS];

  logic               in_bad;
  logic               enter_resp;
  logic               acc_we;
  logic [IDX_W-1:0]   acc_idx;
  logic               acc_bad;
  logic               mem_we;

  assign in_bad = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= DEPTH_WORDS);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    bad_d      = bad_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    enter_resp = 1'b0;
    acc_we     = we_q;
    acc_idx    = idx_q;
    acc_bad    = bad_q;
    mem_we     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          idx_d   = addr[IDX_W+1:2];
          wdata_d = wdata;
          wmask_d = wmask;
          bad_d   = in_bad;
          // With zero wait states RESP is entered on the capture edge itself,
          // so the response is built from the live inputs rather than the captures.
          acc_we  = we;
          acc_idx = addr[IDX_W+1:2];
          acc_bad = in_bad;
          if (WAIT_STATES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            cnt_d   = 4'(WAIT_STATES);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
        mem_we  = we_q && !bad_q;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_resp) begin
      err_d = acc_bad;
      if (acc_bad) begin
        rdata_d = '0;
      end else if (!acc_we) begin
        rdata_d = mem_q[acc_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is not reset; writes commit on the edge that leaves RESP.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wmask_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;
  assign err   = err_q;
  assign ready = (state_q == S_RESP);
  assign busy  = (state_q != S_IDLE);

endmodule
